// File: rtl/nrdiv_pkg.sv
// Shared types and helpers for the Newton-Raphson divider.
// State encoding, error codes, reciprocal seed table and msb search.
package nrdiv_pkg;

  typedef enum logic [2:0] {
    IDLE, PREP, SEED, ITER, MUL, CORR, SIGN, DONE
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_DIV0 = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;

  // Seed reciprocal for Dn in [0.5+i/16, 0.5+(i+1)/16): floor(1/midpoint) in Q1.rw,
  // i.e. floor(2^(rw+5) / (17 + 2i)).
  function automatic logic [63:0] seed_lut(input int unsigned rw, input logic [2:0] idx);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (rw + 5);
    den = 64'd17 + {60'd0, idx, 1'b0};
    return num / den;
  endfunction

  // Index of the highest set bit (0 for a zero input).
  function automatic int msb_index(input logic [63:0] v);
    int m;
    m = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) m = i;
    end
    return m;
  endfunction

endpackage

// File: rtl/nrdiv_lzc.sv
// Leading-one detector: msb index of the divisor magnitude and the
// divisor left-aligned so its leading one sits in the top bit.
module nrdiv_lzc
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         a_i,
  output logic [$clog2(WIDTH)-1:0] m_o,
  output logic [WIDTH-1:0]         dn_o
);

  localparam int MW = $clog2(WIDTH);

  // Locate the leading one and normalise into [0.5,1).
  always_comb begin
    m_o  = MW'(msb_index(64'(a_i)));
    dn_o = a_i << (MW'(WIDTH - 1) - m_o);
  end

endmodule

// File: rtl/nrdiv_core.sv
// Newton-Raphson integer divider with RISC-V divide corner cases.
// Optional build macro NRDIV_POW2_BYPASS_EN: power-of-two divisors are
// resolved by shift/mask in PREP (short latency, identical results).
module nrdiv_core
  import nrdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 3,
  parameter int RW    = WIDTH + 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             unsigned_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] r_o,
  output logic [1:0]       error_o
);

  localparam int MW = $clog2(WIDTH);
  localparam int XW = RW + 2;            // reciprocal holds values up to just over 2.0
  localparam int CW = $clog2(ITERS + 2);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d, d_q, d_d;
  logic             uns_q, uns_d;
  logic [WIDTH-1:0] an_q, an_d, ad_q, ad_d, dn_q, dn_d;
  logic [MW-1:0]    m_q, m_d;
  logic             qs_q, qs_d, rs_q, rs_d;
  logic [1:0]       err_q, err_d;
  logic [XW-1:0]    x_q, x_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] qe_q, qe_d, rem_q, rem_d;
  logic             rdy_q, rdy_d, vld_q, vld_d;
  logic [WIDTH-1:0] q_out_q, q_out_d, r_out_q, r_out_d;
  logic [1:0]       err_out_q, err_out_d;

  logic             neg_n, neg_d;
  logic [WIDTH-1:0] an_c, ad_c, dn_c;
  logic [MW-1:0]    m_c;
  logic [WIDTH+XW-1:0] dx_c, nx_c;
  logic [XW-1:0]    t_c, f_c, x_nxt;
  logic [2*XW-1:0]  xf_c;
  logic [WIDTH-1:0] qe_c, rc_c;
  logic [2*WIDTH-1:0] qd_c;

  assign neg_n = ~uns_q & n_q[WIDTH-1];
  assign neg_d = ~uns_q & d_q[WIDTH-1];
  assign an_c  = neg_n ? (~n_q + 1'b1) : n_q;   // -2^(W-1) stays exact as unsigned
  assign ad_c  = neg_d ? (~d_q + 1'b1) : d_q;

  nrdiv_lzc #(.WIDTH(WIDTH)) u_lzc (
    .a_i  (ad_c),
    .m_o  (m_c),
    .dn_o (dn_c)
  );

  // NR step: X * (2 - Dn*X), both products truncated.
  assign dx_c  = (WIDTH+XW)'(dn_q) * (WIDTH+XW)'(x_q);
  assign t_c   = XW'(dx_c >> WIDTH);
  assign f_c   = (XW'(1) << (RW + 1)) - t_c;
  assign xf_c  = (2*XW)'(x_q) * (2*XW)'(f_c);
  assign x_nxt = XW'(xf_c >> RW);

  // |d| = Dn_value * 2^(m+1), so the quotient estimate drops RW+m+1 bits.
  assign nx_c  = (WIDTH+XW)'(an_q) * (WIDTH+XW)'(x_q);
  assign qe_c  = WIDTH'(nx_c >> (RW + 1 + int'(m_q)));

  // Partial remainder for the current estimate (never negative: qe <= true quotient).
  assign qd_c  = (2*WIDTH)'(qe_q) * (2*WIDTH)'(ad_q);
  assign rc_c  = WIDTH'((2*WIDTH)'(an_q) - qd_c);

  // Next-state and datapath selection for every FSM state.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    d_d       = d_q;
    uns_d     = uns_q;
    an_d      = an_q;
    ad_d      = ad_q;
    dn_d      = dn_q;
    m_d       = m_q;
    qs_d      = qs_q;
    rs_d      = rs_q;
    err_d     = err_q;
    x_d       = x_q;
    cnt_d     = cnt_q;
    qe_d      = qe_q;
    rem_d     = rem_q;
    rdy_d     = rdy_q;
    vld_d     = vld_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    err_out_d = err_out_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          n_d     = n_i;
          d_d     = d_i;
          uns_d   = unsigned_i;
          rdy_d   = 1'b0;
          state_d = PREP;
        end
      end
      PREP: begin
        an_d  = an_c;
        ad_d  = ad_c;
        dn_d  = dn_c;
        m_d   = m_c;
        qs_d  = neg_n ^ neg_d;
        rs_d  = neg_n;
        err_d = ERR_NONE;
        if (d_q == '0) begin
          qe_d    = '1;
          rem_d   = n_q;
          err_d   = ERR_DIV0;
          state_d = SIGN;
        end else if (!uns_q && n_q == {1'b1, {(WIDTH-1){1'b0}}} && d_q == '1) begin
          qe_d    = n_q;
          rem_d   = '0;
          err_d   = ERR_OVF;
          state_d = SIGN;
        end else if (n_q == '0) begin
          qe_d    = '0;
          rem_d   = '0;
          state_d = SIGN;
`ifdef NRDIV_POW2_BYPASS_EN
        end else if ((ad_c & (ad_c - 1'b1)) == '0) begin
          qe_d    = an_c >> m_c;
          rem_d   = an_c & (ad_c - 1'b1);
          state_d = SIGN;
`endif
        end else begin
          state_d = SEED;
        end
      end
      SEED: begin
        x_d     = XW'(seed_lut(RW, dn_q[WIDTH-2 -: 3]));
        cnt_d   = '0;
        state_d = ITER;
      end
      ITER: begin
        x_d = x_nxt;
        if (cnt_q == CW'(ITERS - 1)) begin
          state_d = MUL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUL: begin
        qe_d    = qe_c;
        cnt_d   = '0;
        state_d = CORR;
      end
      CORR: begin
        if (rc_c >= ad_q) begin
          qe_d  = qe_q + 1'b1;
          rem_d = rc_c - ad_q;
        end else begin
          rem_d = rc_c;
        end
        if (cnt_q == CW'(1)) begin
          state_d = SIGN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SIGN: begin
        if (err_q == ERR_NONE) begin
          if (qs_q) qe_d  = ~qe_q + 1'b1;
          if (rs_q) rem_d = ~rem_q + 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        if (!vld_q) begin
          vld_d     = 1'b1;
          q_out_d   = qe_q;
          r_out_d   = rem_q;
          err_out_d = err_q;
        end else if (ready_i) begin
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered outputs; reset abandons any operation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      n_q       <= '0;
      d_q       <= '0;
      uns_q     <= 1'b0;
      an_q      <= '0;
      ad_q      <= '0;
      dn_q      <= '0;
      m_q       <= '0;
      qs_q      <= 1'b0;
      rs_q      <= 1'b0;
      err_q     <= ERR_NONE;
      x_q       <= '0;
      cnt_q     <= '0;
      qe_q      <= '0;
      rem_q     <= '0;
      rdy_q     <= 1'b1;
      vld_q     <= 1'b0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      err_out_q <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      d_q       <= d_d;
      uns_q     <= uns_d;
      an_q      <= an_d;
      ad_q      <= ad_d;
      dn_q      <= dn_d;
      m_q       <= m_d;
      qs_q      <= qs_d;
      rs_q      <= rs_d;
      err_q     <= err_d;
      x_q       <= x_d;
      cnt_q     <= cnt_d;
      qe_q      <= qe_d;
      rem_q     <= rem_d;
      rdy_q     <= rdy_d;
      vld_q     <= vld_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      err_out_q <= err_out_d;
    end
  end

  assign ready_o = rdy_q;
  assign valid_o = vld_q;
  assign q_o     = q_out_q;
  assign r_o     = r_out_q;
  assign error_o = err_out_q;

endmodule

// File: tb/tb_nrdiv_core.sv
// Testbench for nrdiv_core (WIDTH=32, ITERS=3): directed corner cases,
// backpressure, reset mid-operation and randomized operands against a
// plain-arithmetic reference model.
module tb_nrdiv_core;

  localparam int W     = 32;
  localparam int ITERS = 3;

  logic         clk = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic         unsigned_i;
  logic [W-1:0] n_i;
  logic [W-1:0] d_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] q_o;
  logic [W-1:0] r_o;
  logic [1:0]   error_o;

  int n_cmp = 0;
  int n_bad = 0;

  nrdiv_core #(.WIDTH(W), .ITERS(ITERS)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .unsigned_i (unsigned_i),
    .n_i        (n_i),
    .d_i        (d_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .q_o        (q_o),
    .r_o        (r_o),
    .error_o    (error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V M semantics from plain integer arithmetic.
  task automatic model(input logic [W-1:0] n, input logic [W-1:0] d, input logic uns,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic [1:0] e, output int lat);
    longint sn, sd, absd;
    if (uns) begin
      sn = longint'({32'd0, n});
      sd = longint'({32'd0, d});
    end else begin
      sn = longint'($signed(n));
      sd = longint'($signed(d));
    end
    absd = (sd < 0) ? -sd : sd;
    e = 2'd0;
    if (d == 0) begin
      q = '1; r = n; e = 2'd1; lat = 3;
    end else if (!uns && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = n; r = '0; e = 2'd2; lat = 3;
    end else begin
      q = 32'(sn / sd);
      r = 32'(sn % sd);
      lat = (n == 0) ? 3 : ITERS + 7;
`ifdef NRDIV_POW2_BYPASS_EN
      if ((absd & (absd - 1)) == 0) lat = 3;
`endif
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d, input logic uns,
                        input int hold);
    logic [W-1:0] eq, er;
    logic [1:0]   ee;
    int           el, lat;
    model(n, d, uns, eq, er, ee, el);
    @(negedge clk);
    check("ready_before_accept", ready_o, 1'b1);
    valid_i = 1'b1; n_i = n; d_i = d; unsigned_i = uns;
    ready_i = (hold == 0);
    @(posedge clk);
    #1;
    valid_i = 1'b0; n_i = $urandom; d_i = $urandom; unsigned_i = $urandom_range(0, 1);
    lat = 0;
    while (!valid_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, el);
    if (!valid_o) begin
      pulse_reset();
      ready_i = 1'b1;
      return;
    end
    check("quotient", q_o, eq);
    check("remainder", r_o, er);
    check("error", error_o, ee);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", valid_o, 1'b1);
      check("hold_q", q_o, eq);
      check("hold_r", r_o, er);
      check("hold_ready", ready_o, 1'b0);
    end
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_handshake", valid_o, 1'b0);
    check("ready_after_handshake", ready_o, 1'b1);
  endtask

  initial begin
    logic [W-1:0] n, d;
    logic         uns;
    int           vcnt;
    rst_ni = 1'b0; valid_i = 1'b0; unsigned_i = 1'b0;
    n_i = '0; d_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready_o, 1'b1);
    check("rst_valid", valid_o, 1'b0);
    check("rst_q", q_o, 32'd0);
    check("rst_r", r_o, 32'd0);
    check("rst_err", error_o, 2'd0);
    @(negedge clk);
    rst_ni = 1'b1;

    // Directed corner cases
    run_op(32'd100, 32'd7, 1'b1, 0);
    run_op(-32'sd7, 32'd2, 1'b0, 0);
    run_op(32'd7, -32'sd2, 1'b0, 0);
    run_op(32'h1234, 32'd0, 1'b1, 0);
    run_op(32'h1234, 32'd0, 1'b0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_op(32'd0, 32'd5, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 1'b1, 0);
    run_op(32'h8000_0000, 32'd1, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'd3, 1'b1, 0);
    run_op(32'd1000, 32'd16, 1'b1, 0);
    run_op(-32'sd1000, 32'd16, 1'b0, 0);
    run_op(32'd6, 32'd7, 1'b1, 0);
    run_op(32'd7, 32'd7, 1'b0, 0);
    run_op(32'd8, 32'd7, 1'b0, 0);

    // Backpressure: result held for 5 cycles
    run_op(32'd100, 32'd7, 1'b1, 5);

    // Reset while iterating abandons the operation
    @(negedge clk);
    valid_i = 1'b1; n_i = 32'd1000; d_i = 32'd3; unsigned_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    check("midrst_valid", valid_o, 1'b0);
    check("midrst_ready", ready_o, 1'b1);
    check("midrst_q", q_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    vcnt = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (valid_o) vcnt++;
    end
    check("midrst_no_result", vcnt, 0);
    check("midrst_ready_after", ready_o, 1'b1);

    // Randomized operands with boundary mixes
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 5))
        0:       d = 32'd1;
        1:       d = 32'd1 << $urandom_range(0, 31);
        2:       d = 32'($urandom_range(1, 255));
        3:       d = -(32'd1 << $urandom_range(0, 30));
        default: d = $urandom >> $urandom_range(0, 31);
      endcase
      case ($urandom_range(0, 5))
        0:       n = d - 32'd1;
        1:       n = d;
        2:       n = d + 32'd1;
        3:       n = $urandom >> $urandom_range(0, 31);
        default: n = $urandom;
      endcase
      uns = 1'($urandom_range(0, 1));
      run_op(n, d, uns, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
